eql_cam: RTL and testbench
==========================

// Module: eql_cam
// PURPOSE
//  Parametrised, pipelined multi-entry equality matcher (small CAM); the successor of the single-pair comparator.
//  Holds ENTRIES reference words, each with a valid bit, written through a write port.
//  Compares each lookup word against every entry with a valid/ready handshake.
//  Returns the hit mask, the hit flag and the lowest matching index. Serves tag/ID lookup paths.
// PARAMETERS
//  WIDTH    32  compared word width in bits (>=1)
//  ENTRIES  8   number of reference entries (>=2)
//  CHUNK    8   bits per stage-1 compare slice; last slice narrower if WIDTH%CHUNK!=0
// PORTS
//  clk      in   1              clock, all state on rising edge
//  rst_n    in   1              asynchronous active-low reset
//  wr_en    in   1              write entry wr_idx this cycle
//  wr_idx   in   IDX_W          entry index, IDX_W=$clog2(ENTRIES)
//  wr_dat   in   WIDTH          reference word written
//  wr_vld   in   1              valid bit written with the entry (0 = invalidate)
//  clr      in   1              invalidate all entries (data untouched)
//  in_vld   in   1              lookup request valid
//  in_rdy   out  1              lookup request accepted when in_vld&in_rdy
//  in_val   in   WIDTH          lookup word
//  out_vld  out  1              result valid
//  out_rdy  in   1              result consumed when out_vld&out_rdy
//  out_msk  out  ENTRIES        per-entry match (entry valid AND data equal)
//  out_hit  out  1              |out_msk
//  out_idx  out  IDX_W          lowest set index of out_msk; 0 when out_hit=0
// BEHAVIOUR
//  - Reset (async assert, sync release): entry data=0, entry valid=0, s1/s2 valid=0, outputs all 0.
//  - Write: registered; takes effect on next edge. wr_idx>=ENTRIES (non-pow2) is ignored.
//  - clr and wr_en same cycle: clr wins, all valid bits 0 after the edge.
//  - Lookup uses entry state before the edge: a write in the acceptance cycle is not seen by that lookup.
//    Later writes do not alter a lookup already in S1.
//  - Stage S1 (accept edge): register per-entry, per-chunk equality bits
//    (NCHUNK=ceil(WIDTH/CHUNK)) ANDed with the entry valid bit.
//  - Stage S2: AND-reduce the chunks -> msk; priority-encode (lowest index) -> idx; hit=|msk; registered to outputs.
//  - Latency: 2 cycles from accept to out_vld when there is no backpressure. Throughput: 1 per cycle.
//  - Handshake:
//      s2_adv = ~out_vld | out_rdy;  in_rdy = ~s1_vld | s2_adv (combinational, no skid buffer).
//  - Holding: out_* stay stable while out_vld & ~out_rdy. in_val is sampled only when in_vld&in_rdy.
//  - Bubbles: S1 entry stays if S2 is blocked. The pipeline holds at most 2 results in flight.
//  - Async reset mid-operation drops all in-flight lookups; no output pulses after release.
//  - Entry equality is exact over all WIDTH bits. X on unused slice bits is not permitted.
// STRUCTURE
//  - Package eql_cam_pkg: function nchunk(WIDTH,CHUNK) and function prio_enc(msk) -> lowest index.
//  - Sub-module: existing eql_cmp #(.WIDTH(slice)), instanced per entry per chunk in a generate.
//  - Storage: plain flop array, not RAM (entries read in parallel).
// TESTING (default params unless noted; checked against a behavioural scoreboard model)
//  1 Reset then lookup 0x0000_0000 -> out_vld 2 cycles later, out_msk=0, out_hit=0, out_idx=0
//    (zero data is not a hit while entries are invalid).
//  2 Write entries 3 and 5 with 0xDEAD_BEEF; lookup 0xDEAD_BEEF -> out_msk=8'h28, out_hit=1, out_idx=3.
//    Lookup 0xDEAD_BEEE -> miss.
//  3 Same-cycle write entry 1 = 0x1234_5678 and accept lookup 0x1234_5678 -> miss.
//    Repeat the lookup next cycle -> out_idx=1.
//  4 Back-to-back 4 lookups with out_rdy=0 for 3 cycles:
//    in_rdy drops after 2 accepted; results emerge in order, none lost or duplicated.
//  5 clr with wr_en(idx 0, vld=1) the same cycle -> all lookups miss.
//    Assert rst_n low mid-stream -> out_vld=0 immediately and after release.
//  6 WIDTH=13, CHUNK=4, ENTRIES=5: random fill plus 1000 random and equal-forced lookups -> scoreboard match.
//    wr_idx=6 has no effect.

Source files
------------

// File: rtl/eql_cam_pkg.sv
// Shared helpers for the eql_cam matcher: chunk count and lowest-index priority encoder.
package eql_cam_pkg;

   // Upper bound on entry count accepted by prio_enc; callers zero-extend narrower masks.
   localparam int unsigned MAX_ENTRIES = 256;

   function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
      return (width + chunk - 1) / chunk;
   endfunction

   function automatic int unsigned prio_enc(input logic [MAX_ENTRIES-1:0] msk);
      int unsigned idx;
      logic        found;
      idx   = 0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_ENTRIES; i++) begin
         if (msk[i] && !found) begin
            idx   = i;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/eql_cam_cmp.sv
// Single-pair equality comparator, reused as the per-entry, per-chunk slice compare.
module eql_cmp #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             eq
);

   assign eq = (a == b);

endmodule

// File: rtl/eql_cam.sv
// Pipelined multi-entry equality matcher: S1 registers chunked compares, S2 reduces and encodes.
module eql_cam
   import eql_cam_pkg::*;
#(
   parameter  int unsigned WIDTH   = 32,
   parameter  int unsigned ENTRIES = 8,
   parameter  int unsigned CHUNK   = 8,
   localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_idx,
   input  logic [WIDTH-1:0]   wr_dat,
   input  logic               wr_vld,
   input  logic               clr,
   input  logic               in_vld,
   output logic               in_rdy,
   input  logic [WIDTH-1:0]   in_val,
   output logic               out_vld,
   input  logic               out_rdy,
   output logic [ENTRIES-1:0] out_msk,
   output logic               out_hit,
   output logic [IDX_W-1:0]   out_idx
);

   localparam int unsigned NCH = nchunk(WIDTH, CHUNK);

   logic [WIDTH-1:0]             ent_dat [ENTRIES];
   logic [ENTRIES-1:0]           ent_vld;
   logic [ENTRIES-1:0][NCH-1:0]  cmp_eq;
   logic [ENTRIES-1:0][NCH-1:0]  s1_eq;
   logic [ENTRIES-1:0]           s2_msk;
   logic                         s1_vld;
   logic                         s2_adv;
   logic                         acc;
   logic                         wr_ok;

   assign s2_adv = ~out_vld | out_rdy;
   assign in_rdy = ~s1_vld | s2_adv;
   assign acc    = in_vld & in_rdy;
   assign wr_ok  = wr_en & (32'(wr_idx) < ENTRIES);

   // clr takes priority over a same-cycle write, including its data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_vld <= '0;
         for (int unsigned e = 0; e < ENTRIES; e++) begin
            ent_dat[e] <= '0;
         end
      end else if (clr) begin
         ent_vld <= '0;
      end else if (wr_ok) begin
         ent_vld[wr_idx] <= wr_vld;
         ent_dat[wr_idx] <= wr_dat;
      end
   end

   for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
      for (genvar c = 0; c < NCH; c++) begin : g_chunk
         localparam int unsigned LO = c * CHUNK;
         localparam int unsigned HI = (LO + CHUNK > WIDTH) ? WIDTH - 1 : LO + CHUNK - 1;
         eql_cmp #(.WIDTH(HI - LO + 1)) u_cmp (
            .a  (in_val[HI:LO]),
            .b  (ent_dat[e][HI:LO]),
            .eq (cmp_eq[e][c])
         );
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         s1_eq  <= '0;
      end else if (acc) begin
         s1_vld <= 1'b1;
         for (int unsigned e = 0; e < ENTRIES; e++) begin
            s1_eq[e] <= cmp_eq[e] & {NCH{ent_vld[e]}};
         end
      end else if (s2_adv) begin
         s1_vld <= 1'b0;
      end
   end

   always_comb begin
      s2_msk = '0;
      for (int unsigned e = 0; e < ENTRIES; e++) begin
         s2_msk[e] = &s1_eq[e];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld <= 1'b0;
         out_msk <= '0;
         out_hit <= 1'b0;
         out_idx <= '0;
      end else if (s2_adv) begin
         out_vld <= s1_vld;
         if (s1_vld) begin
            out_msk <= s2_msk;
            out_hit <= |s2_msk;
            out_idx <= IDX_W'(prio_enc(MAX_ENTRIES'(s2_msk)));
         end
      end
   end

endmodule

// File: tb/tb_eql_cam.sv
// Self-checking bench for eql_cam: table-driven default-size instance plus a randomised 13x5 instance.
`timescale 1ns/1ps
module tb_eql_cam;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic rst_n;

   // Instance A: default parameters
   logic        a_wr_en, a_wr_vld, a_clr, a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_out_hit;
   logic [2:0]  a_wr_idx, a_out_idx;
   logic [31:0] a_wr_dat, a_in_val;
   logic [7:0]  a_out_msk;

   eql_cam #(.WIDTH(32), .ENTRIES(8), .CHUNK(8)) u_a (
      .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_idx(a_wr_idx), .wr_dat(a_wr_dat),
      .wr_vld(a_wr_vld), .clr(a_clr), .in_vld(a_in_vld), .in_rdy(a_in_rdy), .in_val(a_in_val),
      .out_vld(a_out_vld), .out_rdy(a_out_rdy), .out_msk(a_out_msk), .out_hit(a_out_hit),
      .out_idx(a_out_idx)
   );

   // Instance B: narrow word, ragged last chunk, non-power-of-two entry count
   logic        b_wr_en, b_wr_vld, b_clr, b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_out_hit;
   logic [2:0]  b_wr_idx, b_out_idx;
   logic [12:0] b_wr_dat, b_in_val;
   logic [4:0]  b_out_msk;

   eql_cam #(.WIDTH(13), .ENTRIES(5), .CHUNK(4)) u_b (
      .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_idx(b_wr_idx), .wr_dat(b_wr_dat),
      .wr_vld(b_wr_vld), .clr(b_clr), .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_val(b_in_val),
      .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_msk(b_out_msk), .out_hit(b_out_hit),
      .out_idx(b_out_idx)
   );

   typedef struct packed { logic [7:0] msk; logic hit; logic [2:0] idx; } res_a_t;
   typedef struct packed { logic [4:0] msk; logic hit; logic [2:0] idx; } res_b_t;
   typedef struct { logic [31:0] val; logic [7:0] msk; logic hit; logic [2:0] idx; } vec_t;

   res_a_t qa[$];
   res_b_t qb[$];
   logic [12:0] mb_dat [5];
   logic [4:0]  mb_vld;
   int          b_acc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // A: expectations come from the stimulus tables; monitor pops and checks, and checks holding
   logic        a_hold = 1'b0;
   logic [12:0] a_held;
   always @(negedge clk) begin : mon_a
      res_a_t e;
      if (!rst_n) begin
         qa.delete();
         a_hold = 1'b0;
      end else begin
         if (a_hold)
            chk("a_hold_stable", 64'({a_out_vld, a_out_msk, a_out_hit, a_out_idx}), 64'(a_held));
         if (a_out_vld && a_out_rdy) begin
            if (qa.size() == 0) chk("a_spurious_out", 64'(a_out_vld), 64'(0));
            else begin
               e = qa.pop_front();
               chk("a_msk", 64'(a_out_msk), 64'(e.msk));
               chk("a_hit", 64'(a_out_hit), 64'(e.hit));
               chk("a_idx", 64'(a_out_idx), 64'(e.idx));
            end
         end
         a_hold = a_out_vld && !a_out_rdy;
         a_held = {a_out_vld, a_out_msk, a_out_hit, a_out_idx};
      end
   end

   // B: behavioural model of the entry table computes expectations at acceptance
   always @(negedge clk) begin : mon_b
      res_b_t e;
      logic [4:0] m;
      if (!rst_n) begin
         qb.delete();
         mb_vld = '0;
         for (int i = 0; i < 5; i++) mb_dat[i] = '0;
      end else begin
         if (b_out_vld && b_out_rdy) begin
            if (qb.size() == 0) chk("b_spurious_out", 64'(b_out_vld), 64'(0));
            else begin
               e = qb.pop_front();
               chk("b_msk", 64'(b_out_msk), 64'(e.msk));
               chk("b_hit", 64'(b_out_hit), 64'(e.hit));
               chk("b_idx", 64'(b_out_idx), 64'(e.idx));
            end
         end
         if (b_in_vld && b_in_rdy) begin
            m = '0;
            for (int i = 0; i < 5; i++) m[i] = mb_vld[i] && (mb_dat[i] == b_in_val);
            e.msk = m;
            e.hit = |m;
            e.idx = '0;
            for (int i = 4; i >= 0; i--) if (m[i]) e.idx = 3'(i);
            qb.push_back(e);
            b_acc++;
         end
         if (b_clr) mb_vld = '0;
         else if (b_wr_en && b_wr_idx < 3'd5) begin
            mb_vld[b_wr_idx] = b_wr_vld;
            mb_dat[b_wr_idx] = b_wr_dat;
         end
      end
   end

   task automatic write_a(input logic [2:0] idx, input logic [31:0] dat, input logic vld);
      a_wr_en = 1'b1; a_wr_idx = idx; a_wr_dat = dat; a_wr_vld = vld;
      @(posedge clk); #1;
      a_wr_en = 1'b0;
   endtask

   task automatic lookup_a(input logic [31:0] val, input logic [7:0] msk, input logic hit,
                           input logic [2:0] idx);
      logic acc;
      acc = 1'b0;
      qa.push_back({msk, hit, idx});
      a_in_val = val;
      a_in_vld = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = a_in_rdy;
         @(posedge clk); #1;
      end
      a_in_vld = 1'b0;
      if (!acc) chk("a_lookup_timeout", 64'(acc), 64'(1));
   endtask

   task automatic drain_a();
      for (int i = 0; i < 50 && qa.size() != 0; i++) @(negedge clk);
      chk("a_drain", 64'(qa.size()), 64'(0));
      @(posedge clk); #1;
   endtask

   task automatic write_b(input logic [2:0] idx, input logic [12:0] dat, input logic vld);
      b_wr_en = 1'b1; b_wr_idx = idx; b_wr_dat = dat; b_wr_vld = vld;
      @(posedge clk); #1;
      b_wr_en = 1'b0;
   endtask

   task automatic lookup_b(input logic [12:0] val);
      logic acc;
      acc = 1'b0;
      b_in_val = val;
      b_in_vld = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = b_in_rdy;
         @(posedge clk); #1;
      end
      b_in_vld = 1'b0;
      if (!acc) chk("b_lookup_timeout", 64'(acc), 64'(1));
   endtask

   task automatic drain_b();
      for (int i = 0; i < 50 && qb.size() != 0; i++) @(negedge clk);
      chk("b_drain", 64'(qb.size()), 64'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [6];
      logic [31:0] v4 [4];
      res_a_t      r4 [4];
      int          k, cyc;
      logic        acc;

      tbl[0] = '{32'hDEAD_BEEF, 8'h28, 1'b1, 3'd3};
      tbl[1] = '{32'hDEAD_BEEE, 8'h00, 1'b0, 3'd0};
      tbl[2] = '{32'h0000_0000, 8'h01, 1'b1, 3'd0};
      tbl[3] = '{32'hFFFF_FFFF, 8'h80, 1'b1, 3'd7};
      tbl[4] = '{32'h5EAD_BEEF, 8'h00, 1'b0, 3'd0};
      tbl[5] = '{32'hDEAD_00EF, 8'h00, 1'b0, 3'd0};
      v4[0] = 32'hDEAD_BEEF; r4[0] = {8'h20, 1'b1, 3'd5};
      v4[1] = 32'h1234_5678; r4[1] = {8'h02, 1'b1, 3'd1};
      v4[2] = 32'h0000_0000; r4[2] = {8'h01, 1'b1, 3'd0};
      v4[3] = 32'h0BAD_F00D; r4[3] = {8'h00, 1'b0, 3'd0};

      rst_n = 1'b0;
      a_wr_en = 0; a_wr_idx = 0; a_wr_dat = 0; a_wr_vld = 0; a_clr = 0;
      a_in_vld = 0; a_in_val = 0; a_out_rdy = 1;
      b_wr_en = 0; b_wr_idx = 0; b_wr_dat = 0; b_wr_vld = 0; b_clr = 0;
      b_in_vld = 0; b_in_val = 0; b_out_rdy = 1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_vld", 64'(a_out_vld), 64'(0));
      chk("rst_out_msk", 64'(a_out_msk), 64'(0));
      chk("rst_out_hit", 64'(a_out_hit), 64'(0));
      chk("rst_out_idx", 64'(a_out_idx), 64'(0));
      chk("rst_in_rdy",  64'(a_in_rdy),  64'(1));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Zero lookup on an invalid table: two-cycle latency, miss
      qa.push_back({8'h00, 1'b0, 3'd0});
      a_in_val = 32'h0; a_in_vld = 1'b1;
      @(negedge clk);
      chk("t1_in_rdy", 64'(a_in_rdy), 64'(1));
      @(posedge clk); #1;
      a_in_vld = 1'b0;
      @(negedge clk);
      chk("t1_lat_c1", 64'(a_out_vld), 64'(0));
      @(negedge clk);
      chk("t1_lat_c2", 64'(a_out_vld), 64'(1));
      drain_a();

      write_a(3'd3, 32'hDEAD_BEEF, 1'b1);
      write_a(3'd5, 32'hDEAD_BEEF, 1'b1);
      write_a(3'd0, 32'h0000_0000, 1'b1);
      write_a(3'd7, 32'hFFFF_FFFF, 1'b1);
      for (int i = 0; i < 6; i++) lookup_a(tbl[i].val, tbl[i].msk, tbl[i].hit, tbl[i].idx);
      write_a(3'd3, 32'hDEAD_BEEF, 1'b0);
      lookup_a(32'hDEAD_BEEF, 8'h20, 1'b1, 3'd5);
      drain_a();

      // Write and lookup accepted on the same edge: lookup sees the old table
      a_wr_en = 1'b1; a_wr_idx = 3'd1; a_wr_dat = 32'h1234_5678; a_wr_vld = 1'b1;
      lookup_a(32'h1234_5678, 8'h00, 1'b0, 3'd0);
      a_wr_en = 1'b0;
      lookup_a(32'h1234_5678, 8'h02, 1'b1, 3'd1);
      drain_a();

      // Backpressure: out_rdy low for three cycles while four lookups stream in
      for (int i = 0; i < 4; i++) qa.push_back(r4[i]);
      a_out_rdy = 1'b0; a_in_vld = 1'b1; a_in_val = v4[0]; k = 0;
      for (cyc = 0; cyc < 40 && k < 4; cyc++) begin
         @(negedge clk);
         if (cyc == 2) begin
            chk("bp_accepted", 64'(k), 64'(2));
            chk("bp_in_rdy", 64'(a_in_rdy), 64'(0));
         end
         acc = a_in_rdy;
         @(posedge clk); #1;
         if (acc) k++;
         a_in_val = v4[k % 4];
         if (k == 4) a_in_vld = 1'b0;
         if (cyc == 2) a_out_rdy = 1'b1;
      end
      a_in_vld = 1'b0;
      a_out_rdy = 1'b1;
      chk("bp_all_accepted", 64'(k), 64'(4));
      drain_a();

      // clr beats a same-cycle write
      a_clr = 1'b1;
      a_wr_en = 1'b1; a_wr_idx = 3'd0; a_wr_dat = 32'hCAFE_F00D; a_wr_vld = 1'b1;
      @(posedge clk); #1;
      a_clr = 1'b0; a_wr_en = 1'b0;
      lookup_a(32'hDEAD_BEEF, 8'h00, 1'b0, 3'd0);
      lookup_a(32'hFFFF_FFFF, 8'h00, 1'b0, 3'd0);
      lookup_a(32'hCAFE_F00D, 8'h00, 1'b0, 3'd0);
      lookup_a(32'h0000_0000, 8'h00, 1'b0, 3'd0);
      lookup_a(32'h1234_5678, 8'h00, 1'b0, 3'd0);

      // Async reset with results in flight
      lookup_a(32'h0000_0001, 8'h00, 1'b0, 3'd0);
      lookup_a(32'h0000_0002, 8'h00, 1'b0, 3'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_vld_now", 64'(a_out_vld), 64'(0));
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_mid_vld_after", 64'(a_out_vld), 64'(0));
      end
      @(posedge clk); #1;

      // Instance B: fill with some duplicate words, then random traffic
      for (int i = 0; i < 5; i++)
         write_b(3'(i), (i >= 3) ? mb_dat[1] : 13'($urandom), 1'b1);
      b_acc = 0;
      for (cyc = 0; cyc < 6000 && b_acc < 1000; cyc++) begin
         b_wr_en  = ($urandom_range(0, 3) == 0);
         b_wr_idx = 3'($urandom_range(0, 7));
         b_wr_dat = ($urandom_range(0, 2) == 0) ? mb_dat[$urandom_range(0, 4)] : 13'($urandom);
         b_wr_vld = ($urandom_range(0, 4) != 0);
         b_clr    = ($urandom_range(0, 63) == 0);
         b_in_vld = ($urandom_range(0, 3) != 0);
         b_in_val = ($urandom_range(0, 1) == 0) ? mb_dat[$urandom_range(0, 4)] : 13'($urandom);
         b_out_rdy = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      b_wr_en = 0; b_clr = 0; b_in_vld = 0; b_out_rdy = 1;
      chk("b_random_count", 64'(b_acc >= 1000), 64'(1));
      drain_b();

      // Out-of-range index write must not land anywhere
      b_clr = 1'b1;
      @(posedge clk); #1;
      b_clr = 1'b0;
      write_b(3'd6, 13'h1ABC, 1'b1);
      lookup_b(13'h1ABC);
      drain_b();
      chk("b_idx6_miss", 64'(b_out_hit), 64'(0));
      write_b(3'd2, 13'h1ABC, 1'b1);
      lookup_b(13'h1ABC);
      drain_b();
      chk("b_idx2_msk", 64'(b_out_msk), 64'(5'b00100));
      chk("b_idx2_idx", 64'(b_out_idx), 64'(2));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
